// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write side.
//   REG_ADDR_W / REG_DATA_W : register address / data widths
//   REG_ZERO                : hard-wired zero register, never written
//   wb_req_t                : one pending write {valid, waddr, data}
package regfile_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] waddr;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/regfile_writeback_wb_fifo.sv
// wb_fifo: DEPTH-entry FIFO of wb_req_t buffering mult/div results.
//   clk, rst         : clock, synchronous active-high reset
//   push_i/push_req_i: enqueue push_req_i at wr pointer
//   pop_i            : retire head entry (caller guarantees non-empty)
//   squash_i/addr    : clear valid of every buffered entry with that waddr
//   qa/qb_addr_i     : lookup addresses; qa/qb_hit_o per-entry matches
//   head_o, count_o  : head entry and occupancy
// A squashed entry keeps its slot; only its valid bit drops, so it still
// drains in order and produces no write.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH+1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  wb_req_t               push_req_i,
  input  logic                  pop_i,
  input  logic                  squash_i,
  input  logic [REG_ADDR_W-1:0] squash_addr_i,
  input  logic [REG_ADDR_W-1:0] qa_addr_i,
  input  logic [REG_ADDR_W-1:0] qb_addr_i,
  output wb_req_t               head_o,
  output logic [CNT_W-1:0]      count_o,
  output logic [DEPTH-1:0]      qa_hit_o,
  output logic [DEPTH-1:0]      qb_hit_o
);
  wb_req_t          mem_q [DEPTH];
  wb_req_t          mem_d [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Order matters: squash hits only entries already buffered, then the
  // push lands, so a same-edge push to the squashed address survives.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (squash_i) begin
      for (int i = 0; i < DEPTH; i++)
        if (mem_q[i].valid && mem_q[i].waddr == squash_addr_i)
          mem_d[i].valid = 1'b0;
    end
    if (pop_i) begin
      mem_d[rd_q].valid = 1'b0;
      rd_d = rd_q + PTR_W'(1);
    end
    if (push_i) begin
      mem_d[wr_q] = push_req_i;
      wr_d = wr_q + PTR_W'(1);
    end
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_hit
    assign qa_hit_o[i] = mem_q[i].valid && (mem_q[i].waddr == qa_addr_i);
    assign qb_hit_o[i] = mem_q[i].valid && (mem_q[i].waddr == qb_addr_i);
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/regfile_writeback.sv
// regfile_writeback: owner of the register file write port.
//   clk, rst                 : clock (regfile writes on negedge), sync reset
//   pipe_*                   : MEM/WB pipeline result (has priority)
//   md_valid/md_ready/md_*   : mult/div result handshake, buffered in wb_fifo
//   rs/rt_addr, rs/rt_pending: decode query for buffered (not yet written) regs
//   regWrite/regWaddr/data   : registered write port
//   md_count                 : buffered entry count
module regfile_writeback
  import regfile_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pipe_regwrite,
  input  logic                       pipe_memtoreg,
  input  logic [ADDR_W-1:0]          pipe_waddr,
  input  logic [DATA_W-1:0]          pipe_aluresult,
  input  logic [DATA_W-1:0]          pipe_memdata,
  input  logic                       md_valid,
  output logic                       md_ready,
  input  logic [ADDR_W-1:0]          md_waddr,
  input  logic [DATA_W-1:0]          md_data,
  input  logic [ADDR_W-1:0]          rs_addr,
  input  logic [ADDR_W-1:0]          rt_addr,
  output logic                       rs_pending,
  output logic                       rt_pending,
  output logic                       regWrite,
  output logic [ADDR_W-1:0]          regWaddr,
  output logic [DATA_W-1:0]          data,
  output logic [$clog2(DEPTH+1)-1:0] md_count
);
  localparam int CNT_W = $clog2(DEPTH+1);

  // Buffered entries are wb_req_t, whose field widths come from the package.
  if (DATA_W != REG_DATA_W || ADDR_W != REG_ADDR_W) begin : g_bad_width
    $error("regfile_writeback: DATA_W/ADDR_W must match regfile_pkg");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH-1)) != 0) begin : g_bad_depth
    $error("regfile_writeback: DEPTH must be a power of 2, >= 2");
  end

  logic              regwrite_q, regwrite_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic              pipe_win, fifo_pop, md_push;
  wb_req_t           md_req, head;
  logic [CNT_W-1:0]  cnt;
  logic [DEPTH-1:0]  rs_hit, rt_hit;

  // A pipe write to the zero register is no write at all, so it frees the slot.
  assign pipe_win = pipe_regwrite && (pipe_waddr != REG_ZERO);
  assign fifo_pop = !pipe_win && (cnt != '0);

  // Ready depends on the pre-edge count: a full FIFO refuses even while draining.
  assign md_ready = !rst && (cnt < CNT_W'(DEPTH));
  // Results for $0 complete the handshake but are never stored.
  assign md_push  = md_valid && md_ready && (md_waddr != REG_ZERO);
  assign md_req   = '{valid: 1'b1, waddr: md_waddr, data: md_data};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (md_push),
    .push_req_i   (md_req),
    .pop_i        (fifo_pop),
    .squash_i     (pipe_win),
    .squash_addr_i(pipe_waddr),
    .qa_addr_i    (rs_addr),
    .qb_addr_i    (rt_addr),
    .head_o       (head),
    .count_o      (cnt),
    .qa_hit_o     (rs_hit),
    .qb_hit_o     (rt_hit)
  );

  // Squashed heads drain as a non-write; address/data then hold like idle.
  always_comb begin
    regwrite_d = 1'b0;
    waddr_d    = waddr_q;
    data_d     = data_q;
    if (pipe_win) begin
      regwrite_d = 1'b1;
      waddr_d    = pipe_waddr;
      data_d     = pipe_memtoreg ? pipe_memdata : pipe_aluresult;
    end else if (fifo_pop && head.valid) begin
      regwrite_d = 1'b1;
      waddr_d    = head.waddr;
      data_d     = head.data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regwrite_q <= 1'b0;
      waddr_q    <= '0;
      data_q     <= '0;
    end else begin
      regwrite_q <= regwrite_d;
      waddr_q    <= waddr_d;
      data_q     <= data_d;
    end
  end

  assign rs_pending = (|rs_hit) && (rs_addr != REG_ZERO);
  assign rt_pending = (|rt_hit) && (rt_addr != REG_ZERO);
  assign regWrite   = regwrite_q;
  assign regWaddr   = waddr_q;
  assign data       = data_q;
  assign md_count   = cnt;
endmodule

// File: tb/tb_regfile_writeback.sv
module tb_regfile_writeback;
  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_regwrite, pipe_memtoreg;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_aluresult, pipe_memdata;
  logic        md_valid, md_ready;
  logic [4:0]  md_waddr;
  logic [31:0] md_data;
  logic [4:0]  rs_addr, rt_addr;
  logic        rs_pending, rt_pending;
  logic        regWrite;
  logic [4:0]  regWaddr;
  logic [31:0] data;
  logic [1:0]  md_count;

  always #5 clk = ~clk;

  regfile_writeback #(.DEPTH(2), .DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .pipe_regwrite(pipe_regwrite), .pipe_memtoreg(pipe_memtoreg),
    .pipe_waddr(pipe_waddr), .pipe_aluresult(pipe_aluresult),
    .pipe_memdata(pipe_memdata),
    .md_valid(md_valid), .md_ready(md_ready), .md_waddr(md_waddr),
    .md_data(md_data), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_pending(rs_pending), .rt_pending(rt_pending),
    .regWrite(regWrite), .regWaddr(regWaddr), .data(data),
    .md_count(md_count)
  );

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard of expected register-file commits, in order.
  typedef struct { logic [4:0] a; logic [31:0] d; } wr_t;
  wr_t exp_q[$];
  logic [31:0] rf [32];

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a; e.d = d;
    exp_q.push_back(e);
  endtask

  // Register file model: commits on negedge.
  always @(negedge clk) begin
    if (regWrite === 1'b1) begin
      wr_t e;
      chk("wr_not_r0", {31'd0, regWaddr != 5'd0}, 32'd1);
      rf[regWaddr] = data;
      if (exp_q.size() == 0) begin
        nvec++; nerr++;
        $display("FAIL unexpected_write: got r%0d=%h expected none", regWaddr, data);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", {27'd0, regWaddr}, {27'd0, e.a});
        chk("wr_data", data, e.d);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pipe(input logic we, input logic [4:0] a, input logic [31:0] d);
    pipe_regwrite = we; pipe_memtoreg = 1'b0; pipe_waddr = a; pipe_aluresult = d;
    if (we && a != 5'd0) expect_wr(a, d);
  endtask

  task automatic md(input logic v, input logic [4:0] a, input logic [31:0] d);
    md_valid = v; md_waddr = a; md_data = d;
  endtask

  typedef struct {
    logic        we, m2r;
    logic [4:0]  wa;
    logic [31:0] alu, mem;
    logic        e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_d;
  } vec_t;
  vec_t vecs[6];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    rst = 1'b1;
    pipe_regwrite = 0; pipe_memtoreg = 0; pipe_waddr = 0;
    pipe_aluresult = 0; pipe_memdata = 0;
    md_valid = 0; md_waddr = 0; md_data = 0; rs_addr = 0; rt_addr = 0;

    vecs[0] = '{1, 0,  8, 32'h0000000A, 32'h55,       1,  8, 32'h0000000A};
    vecs[1] = '{1, 1,  3, 32'h1,        32'hDEADBEEF, 1,  3, 32'hDEADBEEF};
    vecs[2] = '{1, 0,  0, 32'hFFFFFFFF, 32'h0,        0,  3, 32'hDEADBEEF};
    vecs[3] = '{0, 0,  5, 32'h7,        32'h0,        0,  3, 32'hDEADBEEF};
    vecs[4] = '{1, 0, 31, 32'h12345678, 32'h9,        1, 31, 32'h12345678};
    vecs[5] = '{1, 1,  1, 32'hCAFE,     32'h0,        1,  1, 32'h0};

    // Reset state
    step(); step();
    chk("rst_regWrite", {31'd0, regWrite}, 0);
    chk("rst_regWaddr", {27'd0, regWaddr}, 0);
    chk("rst_data", data, 0);
    chk("rst_md_count", {30'd0, md_count}, 0);
    chk("rst_md_ready", {31'd0, md_ready}, 0);
    rst = 1'b0;
    #1;
    chk("md_ready_after_rst", {31'd0, md_ready}, 1);

    // Pipeline-only vectors, FIFO empty
    foreach (vecs[i]) begin
      pipe_regwrite = vecs[i].we; pipe_memtoreg = vecs[i].m2r; pipe_waddr = vecs[i].wa;
      pipe_aluresult = vecs[i].alu; pipe_memdata = vecs[i].mem;
      if (vecs[i].e_we) expect_wr(vecs[i].e_wa, vecs[i].e_d);
      step();
      chk($sformatf("v%0d_regWrite", i), {31'd0, regWrite}, {31'd0, vecs[i].e_we});
      chk($sformatf("v%0d_regWaddr", i), {27'd0, regWaddr}, {27'd0, vecs[i].e_wa});
      chk($sformatf("v%0d_data", i), data, vecs[i].e_d);
    end
    pipe(0, 0, 0);
    step();
    chk("rf8", rf[8], 32'hA);
    chk("rf0", rf[0], 32'h0);
    chk("rf1", rf[1], 32'h0);
    chk("rf31", rf[31], 32'h12345678);

    // md result buffered behind three busy pipe cycles
    md(1, 17, 32); pipe(1, 2, 100);
    step();
    md(0, 0, 0);
    rs_addr = 17; rt_addr = 16; #1;
    chk("A_count", {30'd0, md_count}, 1);
    chk("A_rs_pending", {31'd0, rs_pending}, 1);
    chk("A_rt_pending", {31'd0, rt_pending}, 0);
    pipe(1, 4, 200); step();
    pipe(1, 6, 300); step();
    chk("A_count2", {30'd0, md_count}, 1);
    pipe(0, 0, 0); expect_wr(17, 32);
    step();
    chk("A_regWrite", {31'd0, regWrite}, 1);
    chk("A_regWaddr", {27'd0, regWaddr}, 17);
    chk("A_data", data, 32);
    chk("A_count_drained", {30'd0, md_count}, 0);
    chk("A_rs_clear", {31'd0, rs_pending}, 0);

    // Minimum latency: not dequeued at the transfer edge
    md(1, 18, 77);
    step();
    md(0, 0, 0);
    chk("L_regWrite_edge1", {31'd0, regWrite}, 0);
    chk("L_count", {30'd0, md_count}, 1);
    expect_wr(18, 77);
    step();
    chk("L_regWrite_edge2", {31'd0, regWrite}, 1);
    chk("L_regWaddr", {27'd0, regWaddr}, 18);

    // Full FIFO refuses, even while draining
    md(1, 20, 1); pipe(1, 7, 70); step();
    chk("F_count1", {30'd0, md_count}, 1);
    chk("F_ready1", {31'd0, md_ready}, 1);
    md(1, 21, 2); pipe(1, 7, 71); step();
    chk("F_count2", {30'd0, md_count}, 2);
    chk("F_ready_full", {31'd0, md_ready}, 0);
    md(1, 22, 3); pipe(1, 7, 72); step();
    chk("F_count_held", {30'd0, md_count}, 2);
    pipe(0, 0, 0); expect_wr(20, 1); step();
    chk("F_count_drain", {30'd0, md_count}, 1);
    chk("F_ready_again", {31'd0, md_ready}, 1);
    expect_wr(21, 2); step();
    chk("F_count_enq_deq", {30'd0, md_count}, 1);
    md(0, 0, 0); expect_wr(22, 3); step();
    chk("F_count_end", {30'd0, md_count}, 0);

    // md result for $0 is accepted and dropped
    md(1, 0, 5);
    #1;
    chk("Z_ready", {31'd0, md_ready}, 1);
    step();
    md(0, 0, 0);
    chk("Z_count", {30'd0, md_count}, 0);
    chk("Z_regWrite", {31'd0, regWrite}, 0);

    // WAW squash by a younger pipe write
    md(1, 9, 6); pipe(1, 10, 11); step();
    md(0, 0, 0); pipe(1, 9, 4); step();
    rs_addr = 9; #1;
    chk("S_rs_squashed", {31'd0, rs_pending}, 0);
    chk("S_count", {30'd0, md_count}, 1);
    pipe(0, 0, 0); step();
    chk("S_drain_nowrite", {31'd0, regWrite}, 0);
    chk("S_count0", {30'd0, md_count}, 0);
    step();
    chk("S_rf9", rf[9], 4);

    // Same-edge push to the squashed address survives
    md(1, 12, 99); pipe(1, 12, 5); step();
    md(0, 0, 0); rt_addr = 12; #1;
    chk("S2_count", {30'd0, md_count}, 1);
    chk("S2_rt_pending", {31'd0, rt_pending}, 1);
    pipe(0, 0, 0); expect_wr(12, 99); step();
    chk("S2_regWaddr", {27'd0, regWaddr}, 12);
    chk("S2_data", data, 99);

    // Reset discards buffered results
    md(1, 23, 1); pipe(1, 13, 1); step();
    md(1, 24, 2); pipe(1, 13, 2); step();
    chk("R_count_full", {30'd0, md_count}, 2);
    md(0, 0, 0); pipe(0, 0, 0); rst = 1'b1; step();
    chk("R_count", {30'd0, md_count}, 0);
    chk("R_regWrite", {31'd0, regWrite}, 0);
    chk("R_regWaddr", {27'd0, regWaddr}, 0);
    chk("R_ready", {31'd0, md_ready}, 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("R_idle_regWrite", {31'd0, regWrite}, 0);
    chk("R_rf23", rf[23], 0);
    chk("R_rf24", rf[24], 0);
    chk("R_rf13", rf[13], 2);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
